tenv_nssram_wishbone: RTL and testbench
=======================================

# tenv_nssram_wishbone

Parametrised Wishbone slave SRAM model for the test environment; successor to the fixed four-lane byte SRAM. Generalises lane count, lane width and depth, adds programmable wait states and optional incrementing-burst support. Instantiated by testbenches as program memory, exception-handler memory or data memory attached to the CPU core's Wishbone ports.

## Interface
- WADDR, 13, word-address width; depth = 2**WADDR words
- WDATA, 8, width of one byte lane
- NLANES, 4, number of lanes per word (1..8)
- WAIT, 0, wait states inserted before each classic-cycle ack (0..15)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  WADDR  word address
- wb_sel_i  in  NLANES  lane enables
- wb_dat_i  in  NLANES*WDATA  write data, lane k = bits [k*WDATA +: WDATA]
- wb_cti_i  in  3  cycle type (present only with TENV_NSSRAM_BURST_EN)
- wb_dat_o  out  NLANES*WDATA  read data, registered
- wb_ack_o  out  1  acknowledge, registered

## Operation
- Request = wb_cyc_i & wb_stb_i.
- FSM states: IDLE, WAIT, ACK (plus BURST with macro).
- IDLE: on request, WAIT==0 -> ACK; else load counter with WAIT-1 -> WAIT.
- WAIT: request dropped -> IDLE, no access performed (abort); counter==0 -> ACK; else decrement.
- ACK: wb_ack_o=1 for exactly one cycle; access performed on the clock edge entering ACK using address/data/sel sampled on that edge. Next state IDLE (classic) or BURST (see Configuration).
- Write: only lanes with wb_sel_i[k]=1 updated; others retain contents. wb_sel_i=0 still acks, memory unchanged.
- Read: wb_dat_o = full word at address regardless of wb_sel_i; holds last value when not acking.
- Memory contents are not reset and are undefined (X) until written.
- Address wraps naturally; all 2**WADDR words valid, no error response.

## Timing
- Reset: wb_ack_o=0, wb_dat_o=0, FSM=IDLE, counter=0. Reset asserted mid-transaction aborts it; no write committed on that edge.
- Classic latency: request seen at edge N -> wb_ack_o high during cycle N+1+WAIT.
- Ack always followed by one IDLE cycle in classic mode: back-to-back single accesses every 2+WAIT cycles.
- Master holding request through ack starts the next access at the IDLE edge.

## Configuration
- TENV_NSSRAM_BURST_EN defined: wb_cti_i port present. In ACK with request still high and wb_cti_i==3'b010 -> BURST. BURST: wb_ack_o held 1 every cycle, access each edge at current wb_adr_i, no wait states; exits to IDLE when request drops or an ack is given with wb_cti_i==3'b111. cti 3'b000/3'b001 behave as classic.
- Undefined: no wb_cti_i port, no BURST state; every access classic.

## Structure
- Shared package (tenv defines): cycle-type constants CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_END=3'b111; FSM state encodings.
- One sub-module: tenv_nssram_lane, single-lane WDATA x 2**WADDR array with write enable, instantiated NLANES times via generate; FSM and ack logic in the top.

## Test plan
- Reset with request asserted -> wb_ack_o=0, wb_dat_o=0 until rst falls; first ack one cycle (WAIT=0) after release.
- WAIT=3, write 0xDEADBEEF to addr 5 sel=4'b1111, read addr 5 -> ack 4 cycles after each request; read data 0xDEADBEEF.
- Write 0x11223344 to addr 7, then 0xAABBCCDD with sel=4'b0101 -> read 0x11BB33DD.
- WAIT=4, drop wb_stb_i after 2 wait cycles during write -> no ack, addr unchanged on readback.
- Macro on: burst writes to addr 0..3 with cti 010,010,010,111 -> acks on 4 consecutive cycles after first, then IDLE; readback matches.
- NLANES=2, WDATA=16, addr 2**WADDR-1 write/read 0xCAFE0001 -> correct data at top address.

Source files
------------

// File: rtl/tenv_nssram_wishbone_pkg.sv
// Shared definitions for the tenv Wishbone SRAM model.
// Latency: n/a (constants and types only).
// Backpressure: n/a. Holds Wishbone cycle-type codes and the slave FSM state encoding.
package tenv_nssram_wishbone_pkg;

   // Wishbone cycle type identifiers (wb_cti_i)
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   // Slave FSM states; ST_BURST is only reachable when burst support is compiled in
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ACK   = 2'd2,
      ST_BURST = 2'd3
   } state_t;

endpackage

// File: rtl/tenv_nssram_lane.sv
// One byte lane of the SRAM model: WDATA x 2**WADDR array, synchronous write, asynchronous read.
// Latency: write committed on the rising edge with we high; rdata follows addr combinationally.
// Backpressure: none, the owning slave decides when we is asserted.
// Ports: clk, we (lane write enable), addr (word address), wdata (lane write data), rdata (lane read data).
module tenv_nssram_lane #(
   parameter int WADDR = 13,
   parameter int WDATA = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [WADDR-1:0] addr,
   input  logic [WDATA-1:0] wdata,
   output logic [WDATA-1:0] rdata
);

   // Contents are intentionally not reset
   logic [WDATA-1:0] mem [2**WADDR];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/tenv_nssram_wishbone.sv
// Parametrised Wishbone slave SRAM model: NLANES lanes of WDATA bits, 2**WADDR words, WAIT wait states.
// Latency: request seen at edge N gives ack during cycle N+1+WAIT; burst beats ack every cycle.
// Backpressure: slave inserts WAIT cycles before each classic ack; master may abort by dropping request.
// Optional feature macro: TENV_NSSRAM_BURST_EN adds wb_cti_i and incrementing-burst support.
// Ports: clk, rst (async active-high), wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
//        [wb_cti_i], wb_dat_o (registered read data), wb_ack_o (registered ack).
import tenv_nssram_wishbone_pkg::*;

module tenv_nssram_wishbone #(
   parameter int WADDR  = 13,
   parameter int WDATA  = 8,
   parameter int NLANES = 4,
   parameter int WAIT   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_we_i,
   input  logic [WADDR-1:0]        wb_adr_i,
   input  logic [NLANES-1:0]       wb_sel_i,
   input  logic [NLANES*WDATA-1:0] wb_dat_i,
`ifdef TENV_NSSRAM_BURST_EN
   input  logic [2:0]              wb_cti_i,
`endif
   output logic [NLANES*WDATA-1:0] wb_dat_o,
   output logic                    wb_ack_o
);

   // Counter preload: WAIT-1 so that WAIT cycles elapse in ST_WAIT before the ack edge
   localparam logic [3:0] WAIT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

   state_t                    state;
   state_t                    state_nxt;
   logic [3:0]                cnt;
   logic                      req;
   logic                      access;
   logic [NLANES*WDATA-1:0]   rd_word;

   assign req = wb_cyc_i & wb_stb_i;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req) begin
               state_nxt = (WAIT == 0) ? ST_ACK : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_nxt = ST_IDLE;
            end else if (cnt == 4'd0) begin
               state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            state_nxt = ST_IDLE;
`ifdef TENV_NSSRAM_BURST_EN
            if (req && (wb_cti_i == CTI_INCR)) begin
               state_nxt = ST_BURST;
            end
`endif
         end
`ifdef TENV_NSSRAM_BURST_EN
         ST_BURST: begin
            // The end-of-burst beat is still accessed; it is acked from ST_ACK,
            // which then falls back to ST_IDLE.
            if (!req) begin
               state_nxt = ST_IDLE;
            end else if (wb_cti_i == CTI_END) begin
               state_nxt = ST_ACK;
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: an access happens on every edge that enters an acking state.
   // Gated by rst so a request held during reset never commits a write.
   always_comb begin
      access = 1'b0;
      if (!rst && ((state_nxt == ST_ACK) || (state_nxt == ST_BURST))) begin
         access = 1'b1;
      end
   end

   // Wait-state counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 4'd0;
      end else if ((state == ST_IDLE) && req) begin
         cnt <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Registered ack and read data; read data only changes on read accesses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= access;
         if (access && !wb_we_i) begin
            wb_dat_o <= rd_word;
         end
      end
   end

   for (genvar k = 0; k < NLANES; k++) begin : g_lane
      tenv_nssram_lane #(
         .WADDR (WADDR),
         .WDATA (WDATA)
      ) u_lane (
         .clk   (clk),
         .we    (access & wb_we_i & wb_sel_i[k]),
         .addr  (wb_adr_i),
         .wdata (wb_dat_i[k*WDATA +: WDATA]),
         .rdata (rd_word[k*WDATA +: WDATA])
      );
   end

endmodule

// File: tb/tb_tenv_nssram_wishbone.sv
// Bench for tenv_nssram_wishbone: three instances (4x8 WAIT=0, 4x8 WAIT=3, 2x16 WAIT=4).
// Stimulus pushes expected ack cycle/data into a queue; a negedge monitor pops on every ack.
// Burst checks are compiled only when TENV_NSSRAM_BURST_EN is defined.
module tb_tenv_nssram_wishbone;

   localparam int ND = 3;
   localparam int W0 = 0;
   localparam int W1 = 3;
   localparam int W2 = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc_n = 0;
   int   n_test = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   logic        bcyc [ND];
   logic        bstb [ND];
   logic        bwe  [ND];
   logic [12:0] badr [ND];
   logic [3:0]  bsel [ND];
   logic [31:0] bdi  [ND];
   logic [31:0] bdo  [ND];
   logic        back [ND];
`ifdef TENV_NSSRAM_BURST_EN
   logic [2:0]  cti = 3'b000;
`endif

   tenv_nssram_wishbone #(.WADDR(13), .WDATA(8), .NLANES(4), .WAIT(W0)) dut_a (
      .clk(clk), .rst(rst), .wb_cyc_i(bcyc[0]), .wb_stb_i(bstb[0]), .wb_we_i(bwe[0]),
      .wb_adr_i(badr[0]), .wb_sel_i(bsel[0]), .wb_dat_i(bdi[0]),
`ifdef TENV_NSSRAM_BURST_EN
      .wb_cti_i(cti),
`endif
      .wb_dat_o(bdo[0]), .wb_ack_o(back[0]));

   tenv_nssram_wishbone #(.WADDR(13), .WDATA(8), .NLANES(4), .WAIT(W1)) dut_b (
      .clk(clk), .rst(rst), .wb_cyc_i(bcyc[1]), .wb_stb_i(bstb[1]), .wb_we_i(bwe[1]),
      .wb_adr_i(badr[1]), .wb_sel_i(bsel[1]), .wb_dat_i(bdi[1]),
`ifdef TENV_NSSRAM_BURST_EN
      .wb_cti_i(3'b000),
`endif
      .wb_dat_o(bdo[1]), .wb_ack_o(back[1]));

   tenv_nssram_wishbone #(.WADDR(13), .WDATA(16), .NLANES(2), .WAIT(W2)) dut_c (
      .clk(clk), .rst(rst), .wb_cyc_i(bcyc[2]), .wb_stb_i(bstb[2]), .wb_we_i(bwe[2]),
      .wb_adr_i(badr[2]), .wb_sel_i(bsel[2][1:0]), .wb_dat_i(bdi[2]),
`ifdef TENV_NSSRAM_BURST_EN
      .wb_cti_i(3'b000),
`endif
      .wb_dat_o(bdo[2]), .wb_ack_o(back[2]));

   typedef struct {
      int          dut;
      int          cyc;
      logic [31:0] dat;
      bit          chk;
      string       tag;
   } exp_t;

   exp_t scb[$];
   exp_t mon_e;

   function automatic int wait_of(int d);
      return (d == 0) ? W0 : ((d == 1) ? W1 : W2);
   endfunction

   task automatic expect_ack(int d, int c, logic [31:0] v, bit chk, string tag);
      exp_t e;
      e.dut = d; e.cyc = c; e.dat = v; e.chk = chk; e.tag = tag;
      scb.push_back(e);
   endtask

   task automatic drive(int d, logic we, logic [12:0] a, logic [3:0] s, logic [31:0] wd);
      bcyc[d] = 1'b1; bstb[d] = 1'b1; bwe[d] = we; badr[d] = a; bsel[d] = s; bdi[d] = wd;
   endtask

   task automatic release_bus(int d);
      bcyc[d] = 1'b0; bstb[d] = 1'b0; bwe[d] = 1'b0;
   endtask

   // Advance to the next negedge with ack high, bounded
   task automatic wait_ack(int d, string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (back[d] !== 1'b1 && n < 40);
      if (back[d] !== 1'b1) begin
         n_test++; n_fail++;
         $display("FAIL %s: dut%0d ack=%b, required 1 within %0d cycles", tag, d, back[d], n);
      end
   endtask

   // One classic access; reads check data, writes only check ack timing
   task automatic xfer(int d, logic we, logic [12:0] a, logic [3:0] s, logic [31:0] wd,
                       logic [31:0] rexp, string tag);
      @(negedge clk);
      drive(d, we, a, s, wd);
      expect_ack(d, cyc_n + 1 + wait_of(d), rexp, !we, tag);
      wait_ack(d, tag);
      release_bus(d);
   endtask

   task automatic check_reset_outputs(string tag);
      n_test++;
      if (back[0] !== 1'b0 || bdo[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL %s: ack=%b dat=%h, required ack=0 dat=00000000", tag, back[0], bdo[0]);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (back[d] === 1'b1) begin
            n_test++;
            if (scb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_ack: dut%0d at cycle %0d, no ack required", d, cyc_n);
            end else begin
               mon_e = scb.pop_front();
               if (mon_e.dut != d || mon_e.cyc != cyc_n || (mon_e.chk && bdo[d] !== mon_e.dat)) begin
                  n_fail++;
                  $display("FAIL %s: dut%0d cycle %0d dat %h, required dut%0d cycle %0d dat %h",
                           mon_e.tag, d, cyc_n, bdo[d], mon_e.dut, mon_e.cyc, mon_e.dat);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < ND; d++) begin
         bcyc[d] = 1'b0; bstb[d] = 1'b0; bwe[d] = 1'b0;
         badr[d] = '0; bsel[d] = '0; bdi[d] = '0;
      end
      #1 rst = 1'b1;

      // Reset held with a write request pending on the WAIT=0 instance
      drive(0, 1'b1, 13'h010, 4'hF, 32'h0102_0304);
      repeat (3) begin
         @(negedge clk);
         check_reset_outputs("reset_hold");
      end
      rst = 1'b0;
      expect_ack(0, cyc_n + 1, 32'h0, 1'b0, "first_ack_after_reset");
      wait_ack(0, "first_ack_after_reset");
      release_bus(0);
      xfer(0, 1'b0, 13'h010, 4'hF, 32'h0, 32'h0102_0304, "rd_after_reset");

      // Reset asserted with a write pending must not commit it
      xfer(0, 1'b1, 13'h009, 4'hF, 32'h0000_0000, 32'h0, "wr9_zero");
      @(negedge clk);
      drive(0, 1'b1, 13'h009, 4'hF, 32'hFFFF_FFFF);
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_reset_outputs("reset_mid");
      end
      release_bus(0);
      rst = 1'b0;
      xfer(0, 1'b0, 13'h009, 4'hF, 32'h0, 32'h0000_0000, "rd9_after_reset");

      // Lane-select writes
      xfer(0, 1'b1, 13'h007, 4'hF, 32'h1122_3344, 32'h0, "wr7_full");
      xfer(0, 1'b1, 13'h007, 4'b0101, 32'hAABB_CCDD, 32'h0, "wr7_sel0101");
      xfer(0, 1'b0, 13'h007, 4'h0, 32'h0, 32'h11BB_33DD, "rd7_merged");
      xfer(0, 1'b1, 13'h007, 4'b0000, 32'hFFFF_FFFF, 32'h0, "wr7_sel0");
      xfer(0, 1'b0, 13'h007, 4'hF, 32'h0, 32'h11BB_33DD, "rd7_after_sel0");

`ifdef TENV_NSSRAM_BURST_EN
      // Incrementing burst of four writes, last beat marked end-of-burst
      @(negedge clk);
      cti = 3'b010;
      drive(0, 1'b1, 13'h000, 4'hF, 32'hB000_0000);
      for (int i = 0; i < 4; i++) expect_ack(0, cyc_n + 1 + i, 32'h0, 1'b0, "burst_wr");
      for (int i = 0; i < 4; i++) begin
         wait_ack(0, "burst_wr");
         if (i < 3) begin
            badr[0] = 13'(i + 1);
            bdi[0]  = 32'hB000_0000 + 32'(i + 1);
            cti     = (i == 2) ? 3'b111 : 3'b010;
         end
      end
      release_bus(0);
      cti = 3'b000;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++)
         xfer(0, 1'b0, 13'(i), 4'hF, 32'h0, 32'hB000_0000 + 32'(i), "burst_readback");
`endif

      // WAIT=3 instance: latency and held-request back-to-back
      xfer(1, 1'b1, 13'h005, 4'hF, 32'hDEAD_BEEF, 32'h0, "w3_wr5");
      xfer(1, 1'b0, 13'h005, 4'hF, 32'h0, 32'hDEAD_BEEF, "w3_rd5");
      @(negedge clk);
      drive(1, 1'b0, 13'h005, 4'hF, 32'h0);
      expect_ack(1, cyc_n + 1 + W1, 32'hDEAD_BEEF, 1'b1, "w3_held_1");
      expect_ack(1, cyc_n + 1 + W1 + 2 + W1, 32'hDEAD_BEEF, 1'b1, "w3_held_2");
      wait_ack(1, "w3_held_1");
      wait_ack(1, "w3_held_2");
      release_bus(1);

      // 2x16 WAIT=4 instance: top address, abort, lane select
      xfer(2, 1'b1, 13'h1FFF, 4'h3, 32'hCAFE_0001, 32'h0, "c_wr_top");
      xfer(2, 1'b0, 13'h1FFF, 4'h3, 32'h0, 32'hCAFE_0001, "c_rd_top");
      xfer(2, 1'b1, 13'h003, 4'h3, 32'h1234_5678, 32'h0, "c_wr3");
      @(negedge clk);
      drive(2, 1'b1, 13'h003, 4'h3, 32'hFFFF_FFFF);
      repeat (2) @(negedge clk);
      bstb[2] = 1'b0;
      repeat (8) @(negedge clk);
      release_bus(2);
      xfer(2, 1'b0, 13'h003, 4'h3, 32'h0, 32'h1234_5678, "c_rd3_after_abort");
      xfer(2, 1'b1, 13'h003, 4'h1, 32'hFFFF_0000, 32'h0, "c_wr3_lane0");
      xfer(2, 1'b0, 13'h003, 4'h3, 32'h0, 32'h1234_0000, "c_rd3_lane0");

      repeat (5) @(negedge clk);
      n_test++;
      if (scb.size() != 0) begin
         n_fail++;
         $display("FAIL missing_acks: %0d expected acks outstanding, required 0", scb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
      $finish;
   end

endmodule
